// File: rtl/butterfly_lsu.sv
// butterfly_lsu: load/store unit for the ButterFly RV32IM core.
// Accepts one memory request at a time. It steers store bytes onto the bus
// lanes with matching strobes, and returns extended load data to writeback.
// Misaligned, illegal-width and bus-timeout accesses are reported as faults.
module butterfly_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fault_addr_o,
  output logic        dmem_valid_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b11;

  // Width code not defined for the access direction.
  function automatic logic f_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 > 3'd2);
    end else begin
      bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    return bad;
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    logic bad;
    case (f3[1:0])
      2'd1:    bad = lsb[0];
      2'd2:    bad = (lsb != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte strobes for a store of the given width at the given lane.
  function automatic logic [3:0] f_store_strb(input logic [2:0] f3, input logic [1:0] lsb);
    logic [3:0] strb;
    case (f3[1:0])
      2'd0:    strb = 4'b0001 << lsb;
      2'd1:    strb = 4'b0011 << {lsb[1], 1'b0};
      2'd2:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Replicate narrow store data so every lane carries it.
  function automatic logic [31:0] f_store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] data;
    case (f3[1:0])
      2'd0:    data = {4{wd[7:0]}};
      2'd1:    data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    return data;
  endfunction

  // Pick the addressed lane from the bus word and extend it.
  function automatic logic [31:0] f_load_data(input logic [2:0] f3, input logic [1:0] lsb,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lsb)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lsb[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd4:    res = {24'd0, b};
      3'd5:    res = {16'd0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [4:0]  r_rd;
  logic [31:0] r_tmo_cnt;

  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_fault;
  logic [1:0]  r_fault_cause;
  logic [31:0] r_fault_addr;
  logic        r_dmem_valid;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_wstrb;

  logic w_illegal;
  logic w_misaligned;
  logic w_idle_req;
  logic w_accept;
  logic w_tmo_hit;
  logic w_bus_done;
  logic w_stall;

  assign w_illegal    = f_illegal(req_we_i, req_funct3_i);
  assign w_misaligned = f_misaligned(req_funct3_i, req_addr_i[1:0]);
  assign w_idle_req   = (r_state == ST_IDLE) && req_valid_i;
  assign w_accept     = w_idle_req && !w_illegal && !w_misaligned;
  // The last permitted ready-less BUS cycle is the one where the count is TIMEOUT_CYCLES-1.
  assign w_tmo_hit    = (r_state == ST_BUS) && !dmem_ready_i &&
                        (TIMEOUT_CYCLES != 32'd0) &&
                        (r_tmo_cnt == (TIMEOUT_CYCLES - 32'd1));
  assign w_bus_done   = (r_state == ST_BUS) && (dmem_ready_i || w_tmo_hit);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pipeline stall.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_accept;
        if (w_accept) begin
          w_state_nxt = ST_BUS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUS: begin
        w_stall = !dmem_ready_i && !w_tmo_hit;
        if (dmem_ready_i || w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_stall     = 1'b0;
      end
    endcase
  end

  assign stall_o = w_stall;

  // Count BUS cycles spent waiting for ready; restarts on every accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tmo_cnt <= 32'd0;
    end else if (w_accept) begin
      r_tmo_cnt <= 32'd0;
    end else if ((r_state == ST_BUS) && !dmem_ready_i) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end

  // Keep a private copy of the request so req_* may change during BUS.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_rd     <= 5'd0;
    end else if (w_accept) begin
      r_we     <= req_we_i;
      r_funct3 <= req_funct3_i;
      r_addr   <= req_addr_i;
      r_rd     <= req_rd_i;
    end
  end

  // Bus request: launched on accept, held through BUS, dropped on completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dmem_valid <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_dmem_valid <= 1'b1;
      r_dmem_we    <= req_we_i;
      r_dmem_addr  <= {req_addr_i[31:2], 2'b00};
      r_dmem_wdata <= req_we_i ? f_store_data(req_funct3_i, req_wdata_i) : 32'd0;
      r_dmem_wstrb <= req_we_i ? f_store_strb(req_funct3_i, req_addr_i[1:0]) : 4'd0;
    end else if (w_bus_done) begin
      r_dmem_valid <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_wstrb <= 4'd0;
    end
  end

  // One-cycle writeback and fault pulses; illegal outranks misaligned.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_data     <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_cause <= 2'b00;
      r_fault_addr  <= 32'd0;
    end else begin
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_data     <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_cause <= 2'b00;
      r_fault_addr  <= 32'd0;
      if (w_idle_req && w_illegal) begin
        r_fault       <= 1'b1;
        r_fault_cause <= CAUSE_ILLEGAL;
        r_fault_addr  <= req_addr_i;
      end else if (w_idle_req && w_misaligned) begin
        r_fault       <= 1'b1;
        r_fault_cause <= CAUSE_MISALIGNED;
        r_fault_addr  <= req_addr_i;
      end else if ((r_state == ST_BUS) && dmem_ready_i && !r_we) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= f_load_data(r_funct3, r_addr[1:0], dmem_rdata_i);
      end else if (w_tmo_hit) begin
        r_fault       <= 1'b1;
        r_fault_cause <= CAUSE_TIMEOUT;
        r_fault_addr  <= r_addr;
      end
    end
  end

  assign wb_valid_o    = r_wb_valid;
  assign wb_rd_o       = r_wb_rd;
  assign wb_data_o     = r_wb_data;
  assign fault_o       = r_fault;
  assign fault_cause_o = r_fault_cause;
  assign fault_addr_o  = r_fault_addr;
  assign dmem_valid_o  = r_dmem_valid;
  assign dmem_we_o     = r_dmem_we;
  assign dmem_addr_o   = r_dmem_addr;
  assign dmem_wdata_o  = r_dmem_wdata;
  assign dmem_wstrb_o  = r_dmem_wstrb;

endmodule

// File: tb/tb_butterfly_lsu.sv
// Testbench for butterfly_lsu: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_butterfly_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        stall, wb_valid, fault, dmem_valid, dmem_we, dmem_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  fault_cause;
  logic [3:0]  dmem_wstrb;

  int n_vec = 0;
  int n_err = 0;

  butterfly_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_funct3_i(req_funct3), .req_rd_i(req_rd),
    .stall_o(stall), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .fault_o(fault), .fault_cause_o(fault_cause), .fault_addr_o(fault_addr),
    .dmem_valid_o(dmem_valid), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_wstrb_o(dmem_wstrb),
    .dmem_rdata_i(dmem_rdata), .dmem_ready_i(dmem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (spec arithmetic) ----------------
  function automatic bit is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 <= 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_aligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % 32'(acc_bytes(f3))) == 32'd0;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    int n = acc_bytes(f3);
    int off = int'(a % 32'd4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = acc_bytes(f3);
    if (n == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    int n = acc_bytes(f3);
    int off = int'(a % 32'd4);
    logic [31:0] v;
    logic [31:0] mask;
    v = rdata >> (8 * off);
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic        m_we;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic [4:0]  m_rd;
  logic        e_wbv = 1'b0, e_fault = 1'b0, e_dv = 1'b0, e_dwe = 1'b0;
  logic [4:0]  e_rd;
  logic [31:0] e_wbd, e_faddr, e_daddr, e_dwd;
  logic [1:0]  e_cause;
  logic [3:0]  e_strb;
  bit          ms_stall = 1'b0;

  // Compare DUT against model mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_wait = 0; ms_stall = 1'b0;
      e_wbv = 1'b0; e_fault = 1'b0; e_dv = 1'b0;
      chk("rst_dmem_valid", 32'(dmem_valid), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
    end else begin
      if (m_busy) ms_stall = !dmem_ready && (m_wait + 1 != TMO);
      else ms_stall = req_valid && is_legal(req_we, req_funct3) && is_aligned(req_funct3, req_addr);
      chk("stall", 32'(stall), 32'(ms_stall));
      chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
      chk("fault", 32'(fault), 32'(e_fault));
      chk("dmem_valid", 32'(dmem_valid), 32'(e_dv));
      chk("fault_and_wb", 32'(fault & wb_valid), 32'd0);
      if (e_wbv) begin
        chk("wb_rd", 32'(wb_rd), 32'(e_rd));
        chk("wb_data", wb_data, e_wbd);
      end
      if (e_fault) begin
        chk("fault_cause", 32'(fault_cause), 32'(e_cause));
        chk("fault_addr", fault_addr, e_faddr);
      end
      if (e_dv) begin
        chk("dmem_we", 32'(dmem_we), 32'(e_dwe));
        chk("dmem_addr", dmem_addr, e_daddr);
        chk("dmem_wdata", dmem_wdata, e_dwd);
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(e_strb));
      end
      e_wbv = 1'b0;
      e_fault = 1'b0;
      if (!m_busy) begin
        if (req_valid) begin
          if (!is_legal(req_we, req_funct3)) begin
            e_fault = 1'b1; e_cause = 2'b11; e_faddr = req_addr;
          end else if (!is_aligned(req_funct3, req_addr)) begin
            e_fault = 1'b1; e_cause = 2'b01; e_faddr = req_addr;
          end else begin
            m_busy = 1'b1; m_wait = 0;
            m_we = req_we; m_f3 = req_funct3; m_addr = req_addr; m_rd = req_rd;
            e_dv = 1'b1; e_dwe = req_we;
            e_daddr = req_addr - (req_addr % 32'd4);
            e_dwd  = req_we ? exp_wdata(req_funct3, req_wdata) : 32'd0;
            e_strb = req_we ? exp_strb(req_funct3, req_addr) : 4'd0;
          end
        end
      end else if (dmem_ready) begin
        m_busy = 1'b0; e_dv = 1'b0;
        if (!m_we) begin
          e_wbv = 1'b1; e_rd = m_rd; e_wbd = exp_load(m_f3, m_addr, dmem_rdata);
        end
      end else if (m_wait + 1 == TMO) begin
        m_busy = 1'b0; e_dv = 1'b0;
        e_fault = 1'b1; e_cause = 2'b10; e_faddr = m_addr;
      end else begin
        m_wait++;
      end
    end
  end

  // ---------------- directed helpers ----------------
  // One legal access with 'waits' ready-less BUS cycles; reports what was observed.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                        output logic [31:0] a_addr, output logic [31:0] a_wd,
                        output logic [3:0] a_strb, output logic a_we,
                        output int stall_cnt, output int bus_cyc, output int stable,
                        output int wb_cnt, output int wb_at, output logic [31:0] wb_d);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = 5'd9; dmem_ready = 1'b0; dmem_rdata = rdata;
    stall_cnt = 0; bus_cyc = 0; stable = 1; wb_cnt = 0; wb_at = -1; wb_d = 32'd0;
    a_addr = 32'd0; a_wd = 32'd0; a_strb = 4'd0; a_we = 1'b0;
    @(negedge clk);
    if (stall) stall_cnt++;
    tick();
    for (int k = 0; k <= waits; k++) begin
      dmem_ready = (k == waits);
      @(negedge clk);
      if (dmem_valid) bus_cyc++;
      if (stall) stall_cnt++;
      if (k == 0) begin
        a_addr = dmem_addr; a_wd = dmem_wdata; a_strb = dmem_wstrb; a_we = dmem_we;
      end else if (dmem_addr !== a_addr || dmem_wdata !== a_wd ||
                   dmem_wstrb !== a_strb || dmem_we !== a_we) begin
        stable = 0;
      end
      tick();
    end
    req_valid = 1'b0; dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wb_valid) begin
        wb_cnt++;
        wb_d = wb_data;
        if (wb_at < 0) wb_at = k;
      end
      tick();
    end
  endtask

  // Present a bad request for one cycle and capture the fault pulse.
  task automatic fault_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           output logic st, output int dv, output logic f,
                           output logic [1:0] c, output logic [31:0] fa);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = 32'hCAFE_F00D; req_rd = 5'd3;
    @(negedge clk);
    st = stall; dv = int'(dmem_valid);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    f = fault; c = fault_cause; fa = fault_addr; dv += int'(dmem_valid);
    tick();
  endtask

  logic [31:0] a_addr, a_wd, wb_d, fa;
  logic [3:0]  a_strb;
  logic        a_we, st, f;
  logic [1:0]  c;
  int          stall_cnt, bus_cyc, stable, wb_cnt, wb_at, dv;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_funct3 = 3'd0; req_rd = 5'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;

    // Model pins against hand-computed values.
    chk("model_lb", exp_load(3'd0, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
    chk("model_lhu", exp_load(3'd5, 32'h102, 32'h80FF_0000), 32'h0000_80FF);
    chk("model_sh_strb", 32'(exp_strb(3'd1, 32'h202)), 32'h0000_000C);
    chk("model_sb_wdata", exp_wdata(3'd0, 32'h1234_5678), 32'h7878_7878);

    repeat (2) @(negedge clk);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_fault_addr", fault_addr, 32'd0);
    chk("reset_dmem_addr", dmem_addr, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    access(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEAD_BEEF, 0,
           a_addr, a_wd, a_strb, a_we, stall_cnt, bus_cyc, stable, wb_cnt, wb_at, wb_d);
    chk("lw_addr", a_addr, 32'h100);
    chk("lw_we", 32'(a_we), 32'd0);
    chk("lw_strb", 32'(a_strb), 32'd0);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd1);
    chk("lw_wb_count", 32'(wb_cnt), 32'd1);
    chk("lw_wb_slot", 32'(wb_at), 32'd0);
    chk("lw_wb_data", wb_d, 32'hDEAD_BEEF);

    access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 0,
           a_addr, a_wd, a_strb, a_we, stall_cnt, bus_cyc, stable, wb_cnt, wb_at, wb_d);
    chk("lb_data", wb_d, 32'hFFFF_FF80);
    access(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF_0000, 0,
           a_addr, a_wd, a_strb, a_we, stall_cnt, bus_cyc, stable, wb_cnt, wb_at, wb_d);
    chk("lbu_data", wb_d, 32'h0000_0080);
    access(1'b0, 3'd5, 32'h102, 32'd0, 32'h80FF_0000, 0,
           a_addr, a_wd, a_strb, a_we, stall_cnt, bus_cyc, stable, wb_cnt, wb_at, wb_d);
    chk("lhu_data", wb_d, 32'h0000_80FF);

    access(1'b1, 3'd0, 32'h201, 32'h1234_5678, 32'd0, 0,
           a_addr, a_wd, a_strb, a_we, stall_cnt, bus_cyc, stable, wb_cnt, wb_at, wb_d);
    chk("sb_addr", a_addr, 32'h200);
    chk("sb_strb", 32'(a_strb), 32'h2);
    chk("sb_wdata", a_wd, 32'h7878_7878);
    chk("sb_no_wb", 32'(wb_cnt), 32'd0);
    access(1'b1, 3'd1, 32'h202, 32'h1234_5678, 32'd0, 0,
           a_addr, a_wd, a_strb, a_we, stall_cnt, bus_cyc, stable, wb_cnt, wb_at, wb_d);
    chk("sh_strb", 32'(a_strb), 32'hC);
    chk("sh_wdata", a_wd, 32'h5678_5678);
    chk("sh_no_wb", 32'(wb_cnt), 32'd0);

    // Three wait states: four BUS cycles, stall for accept plus three waits.
    access(1'b0, 3'd2, 32'h180, 32'd0, 32'h0BAD_F00D, 3,
           a_addr, a_wd, a_strb, a_we, stall_cnt, bus_cyc, stable, wb_cnt, wb_at, wb_d);
    chk("wait_bus_cycles", 32'(bus_cyc), 32'd4);
    chk("wait_stable", 32'(stable), 32'd1);
    chk("wait_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("wait_wb_count", 32'(wb_cnt), 32'd1);
    chk("wait_wb_data", wb_d, 32'h0BAD_F00D);

    fault_req(1'b0, 3'd2, 32'h102, st, dv, f, c, fa);
    chk("mis_stall", 32'(st), 32'd0);
    chk("mis_no_bus", 32'(dv), 32'd0);
    chk("mis_fault", 32'(f), 32'd1);
    chk("mis_cause", 32'(c), 32'h1);
    chk("mis_addr", fa, 32'h102);
    fault_req(1'b1, 3'd5, 32'h103, st, dv, f, c, fa);
    chk("ill_no_bus", 32'(dv), 32'd0);
    chk("ill_cause", 32'(c), 32'h3);
    chk("ill_addr", fa, 32'h103);

    // Timeout: ready never comes.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; dmem_ready = 1'b0;
    tick();
    bus_cyc = 0; f = 1'b0; c = 2'b00; st = 1'b1; dv = 1;
    for (int k = 0; k < 10 && !f; k++) begin
      @(negedge clk);
      if (fault) begin
        f = 1'b1; c = fault_cause; fa = fault_addr; dv = int'(dmem_valid);
      end else if (dmem_valid) begin
        bus_cyc++; st = stall;
      end
      tick();
      if (!st) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("tmo_fault_seen", 32'(f), 32'd1);
    chk("tmo_bus_cycles", 32'(bus_cyc), 32'd4);
    chk("tmo_last_stall", 32'(st), 32'd0);
    chk("tmo_cause", 32'(c), 32'h2);
    chk("tmo_addr", fa, 32'h300);
    chk("tmo_valid_low", 32'(dv), 32'd0);

    // Reset in the middle of a BUS access.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400; dmem_ready = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("arst_dmem_valid", 32'(dmem_valid), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_wb_fault", 32'(wb_valid | fault), 32'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1; dmem_ready = 1'b1;
    dv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dv += int'(wb_valid) + int'(fault) + int'(dmem_valid);
      tick();
    end
    chk("arst_quiet_after", 32'(dv), 32'd0);

    // Randomized traffic; requests stay stable while the model says stalled.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!ms_stall) begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 8) begin
          if (we) begin
            f3 = 3'($urandom_range(0, 2));
          end else begin
            int idx = int'($urandom_range(0, 4));
            f3 = (idx < 3) ? 3'(idx) : 3'(idx + 1);
          end
        end else begin
          f3 = 3'($urandom_range(0, 7));
        end
        a = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
          else if (f3[1:0] == 2'd1) a[0] = 1'b0;
        end
        req_valid  = ($urandom_range(0, 2) != 0);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom_range(0, 31));
      end
      dmem_ready = ($urandom_range(0, 9) < 6);
      dmem_rdata = $urandom;
      tick();
    end
    req_valid = 1'b0; dmem_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
